// File: rtl/fbw_arbiter.sv
// Per-frame round-robin arbiter sharing one frame-buffer write port between two clients,
// with a programmable inactivity watchdog that force-releases a stalled owner.
module fbw_arbiter #(
    parameter int ROW_W   = 6,
    parameter int COL_W   = 6,
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    output logic              c0_gnt,
    input  logic [ROW_W-1:0]  c0_row_addr,
    input  logic              c0_row_store,
    input  logic              c0_row_swap,
    input  logic [DATA_W-1:0] c0_data,
    input  logic [COL_W-1:0]  c0_col_addr,
    input  logic              c0_wren,
    input  logic              c0_frame_swap,
    output logic              c0_row_rdy,
    output logic              c0_frame_rdy,
    input  logic              c1_req,
    output logic              c1_gnt,
    input  logic [ROW_W-1:0]  c1_row_addr,
    input  logic              c1_row_store,
    input  logic              c1_row_swap,
    input  logic [DATA_W-1:0] c1_data,
    input  logic [COL_W-1:0]  c1_col_addr,
    input  logic              c1_wren,
    input  logic              c1_frame_swap,
    output logic              c1_row_rdy,
    output logic              c1_frame_rdy,
    output logic [ROW_W-1:0]  fbw_row_addr,
    output logic              fbw_row_store,
    input  logic              fbw_row_rdy,
    output logic              fbw_row_swap,
    output logic [DATA_W-1:0] fbw_data,
    output logic [COL_W-1:0]  fbw_col_addr,
    output logic              fbw_wren,
    output logic              frame_swap,
    input  logic              frame_rdy,
    output logic              arb_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] WD_LAST = WD_EN ? TO_W'(TIMEOUT - 1) : '0;

    state_t          state_r;
    logic            owner_r;
    logic            last_owner_r;
    logic [TO_W-1:0] wd_cnt_r;

    logic own_req_s;
    logic own_fs_s;
    logic own_act_s;
    logic wd_expire_s;
    logic pick_c0_s;

    // owner_r is only meaningful in ST_GRANT; these decode the owner's control inputs
    assign own_req_s   = owner_r ? c1_req : c0_req;
    assign own_fs_s    = owner_r ? c1_frame_swap : c0_frame_swap;
    assign own_act_s   = owner_r ? (c1_wren | c1_row_store | c1_row_swap | c1_frame_swap)
                                 : (c0_wren | c0_row_store | c0_row_swap | c0_frame_swap);
    assign wd_expire_s = WD_EN && (wd_cnt_r == WD_LAST) && !own_act_s;
    // On a tie, the client that did not own the port last wins
    assign pick_c0_s   = c0_req && (!c1_req || last_owner_r);

    // Arbitration FSM with registered grants, timeout pulse and watchdog counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            c0_gnt       <= 1'b0;
            c1_gnt       <= 1'b0;
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            wd_cnt_r     <= '0;
            arb_timeout  <= 1'b0;
        end else begin
            arb_timeout <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    wd_cnt_r <= '0;
                    if (pick_c0_s) begin
                        state_r      <= ST_GRANT;
                        c0_gnt       <= 1'b1;
                        owner_r      <= 1'b0;
                        last_owner_r <= 1'b0;
                    end else if (c1_req) begin
                        state_r      <= ST_GRANT;
                        c1_gnt       <= 1'b1;
                        owner_r      <= 1'b1;
                        last_owner_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (own_fs_s || !own_req_s || wd_expire_s) begin
                        state_r     <= ST_RELEASE;
                        c0_gnt      <= 1'b0;
                        c1_gnt      <= 1'b0;
                        wd_cnt_r    <= '0;
                        arb_timeout <= !own_fs_s && own_req_s;
                    end else if (!WD_EN || own_act_s) begin
                        wd_cnt_r <= '0;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + TO_W'(1);
                    end
                end
                ST_RELEASE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    c0_gnt   <= 1'b0;
                    c1_gnt   <= 1'b0;
                    wd_cnt_r <= '0;
                end
            endcase
        end
    end

    // Write path and ready steering: AND-OR select on the mutually exclusive grants
    assign fbw_row_addr  = ({ROW_W{c0_gnt}} & c0_row_addr) | ({ROW_W{c1_gnt}} & c1_row_addr);
    assign fbw_col_addr  = ({COL_W{c0_gnt}} & c0_col_addr) | ({COL_W{c1_gnt}} & c1_col_addr);
    assign fbw_data      = ({DATA_W{c0_gnt}} & c0_data) | ({DATA_W{c1_gnt}} & c1_data);
    assign fbw_row_store = (c0_gnt & c0_row_store) | (c1_gnt & c1_row_store);
    assign fbw_row_swap  = (c0_gnt & c0_row_swap) | (c1_gnt & c1_row_swap);
    assign fbw_wren      = (c0_gnt & c0_wren) | (c1_gnt & c1_wren);
    assign frame_swap    = (c0_gnt & c0_frame_swap) | (c1_gnt & c1_frame_swap);
    assign c0_row_rdy    = c0_gnt & fbw_row_rdy;
    assign c1_row_rdy    = c1_gnt & fbw_row_rdy;
    assign c0_frame_rdy  = c0_gnt & frame_rdy;
    assign c1_frame_rdy  = c1_gnt & frame_rdy;

endmodule

// File: tb/tb_fbw_arbiter.sv
// Scoreboard bench for fbw_arbiter: per-cycle expectations are queued with the stimulus
// and drained against the outputs on the falling edge of the same cycle.
module tb_fbw_arbiter;

    localparam int ROW_W = 6;
    localparam int COL_W = 6;
    localparam int DATA_W = 24;

    localparam int S_C0G = 0, S_C1G = 1, S_C0RR = 2, S_C1RR = 3, S_C0FR = 4, S_C1FR = 5;
    localparam int S_RADDR = 6, S_RSTORE = 7, S_RSWAP = 8, S_DATA = 9, S_CADDR = 10;
    localparam int S_WREN = 11, S_FSWAP = 12, S_TMO = 13, S_NT_C0G = 14, S_NT_TMO = 15;

    logic clk = 1'b0;
    logic rst;
    logic c0_req, c0_row_store, c0_row_swap, c0_wren, c0_frame_swap;
    logic c1_req, c1_row_store, c1_row_swap, c1_wren, c1_frame_swap;
    logic [ROW_W-1:0] c0_row_addr, c1_row_addr;
    logic [COL_W-1:0] c0_col_addr, c1_col_addr;
    logic [DATA_W-1:0] c0_data, c1_data;
    logic fbw_row_rdy, frame_rdy;

    logic c0_gnt, c1_gnt, c0_row_rdy, c1_row_rdy, c0_frame_rdy, c1_frame_rdy;
    logic [ROW_W-1:0] fbw_row_addr;
    logic [COL_W-1:0] fbw_col_addr;
    logic [DATA_W-1:0] fbw_data;
    logic fbw_row_store, fbw_row_swap, fbw_wren, frame_swap, arb_timeout;

    logic nt_c0_gnt, nt_c1_gnt, nt_c0_row_rdy, nt_c1_row_rdy, nt_c0_frame_rdy, nt_c1_frame_rdy;
    logic [ROW_W-1:0] nt_fbw_row_addr;
    logic [COL_W-1:0] nt_fbw_col_addr;
    logic [DATA_W-1:0] nt_fbw_data;
    logic nt_fbw_row_store, nt_fbw_row_swap, nt_fbw_wren, nt_frame_swap, nt_arb_timeout;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          id;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    fbw_arbiter #(.ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W), .TIMEOUT(8), .TO_W(13)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_gnt(c0_gnt), .c0_row_addr(c0_row_addr), .c0_row_store(c0_row_store),
        .c0_row_swap(c0_row_swap), .c0_data(c0_data), .c0_col_addr(c0_col_addr), .c0_wren(c0_wren),
        .c0_frame_swap(c0_frame_swap), .c0_row_rdy(c0_row_rdy), .c0_frame_rdy(c0_frame_rdy),
        .c1_req(c1_req), .c1_gnt(c1_gnt), .c1_row_addr(c1_row_addr), .c1_row_store(c1_row_store),
        .c1_row_swap(c1_row_swap), .c1_data(c1_data), .c1_col_addr(c1_col_addr), .c1_wren(c1_wren),
        .c1_frame_swap(c1_frame_swap), .c1_row_rdy(c1_row_rdy), .c1_frame_rdy(c1_frame_rdy),
        .fbw_row_addr(fbw_row_addr), .fbw_row_store(fbw_row_store), .fbw_row_rdy(fbw_row_rdy),
        .fbw_row_swap(fbw_row_swap), .fbw_data(fbw_data), .fbw_col_addr(fbw_col_addr),
        .fbw_wren(fbw_wren), .frame_swap(frame_swap), .frame_rdy(frame_rdy),
        .arb_timeout(arb_timeout)
    );

    fbw_arbiter #(.ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W), .TIMEOUT(0), .TO_W(13)) dut_nt (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_gnt(nt_c0_gnt), .c0_row_addr(c0_row_addr), .c0_row_store(c0_row_store),
        .c0_row_swap(c0_row_swap), .c0_data(c0_data), .c0_col_addr(c0_col_addr), .c0_wren(c0_wren),
        .c0_frame_swap(c0_frame_swap), .c0_row_rdy(nt_c0_row_rdy), .c0_frame_rdy(nt_c0_frame_rdy),
        .c1_req(c1_req), .c1_gnt(nt_c1_gnt), .c1_row_addr(c1_row_addr), .c1_row_store(c1_row_store),
        .c1_row_swap(c1_row_swap), .c1_data(c1_data), .c1_col_addr(c1_col_addr), .c1_wren(c1_wren),
        .c1_frame_swap(c1_frame_swap), .c1_row_rdy(nt_c1_row_rdy), .c1_frame_rdy(nt_c1_frame_rdy),
        .fbw_row_addr(nt_fbw_row_addr), .fbw_row_store(nt_fbw_row_store), .fbw_row_rdy(fbw_row_rdy),
        .fbw_row_swap(nt_fbw_row_swap), .fbw_data(nt_fbw_data), .fbw_col_addr(nt_fbw_col_addr),
        .fbw_wren(nt_fbw_wren), .frame_swap(nt_frame_swap), .frame_rdy(frame_rdy),
        .arb_timeout(nt_arb_timeout)
    );

    function automatic string sig_name(input int id);
        case (id)
            S_C0G:    return "c0_gnt";
            S_C1G:    return "c1_gnt";
            S_C0RR:   return "c0_row_rdy";
            S_C1RR:   return "c1_row_rdy";
            S_C0FR:   return "c0_frame_rdy";
            S_C1FR:   return "c1_frame_rdy";
            S_RADDR:  return "fbw_row_addr";
            S_RSTORE: return "fbw_row_store";
            S_RSWAP:  return "fbw_row_swap";
            S_DATA:   return "fbw_data";
            S_CADDR:  return "fbw_col_addr";
            S_WREN:   return "fbw_wren";
            S_FSWAP:  return "frame_swap";
            S_TMO:    return "arb_timeout";
            S_NT_C0G: return "nt_c0_gnt";
            S_NT_TMO: return "nt_arb_timeout";
            default:  return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] sig_obs(input int id);
        case (id)
            S_C0G:    return 32'(c0_gnt);
            S_C1G:    return 32'(c1_gnt);
            S_C0RR:   return 32'(c0_row_rdy);
            S_C1RR:   return 32'(c1_row_rdy);
            S_C0FR:   return 32'(c0_frame_rdy);
            S_C1FR:   return 32'(c1_frame_rdy);
            S_RADDR:  return 32'(fbw_row_addr);
            S_RSTORE: return 32'(fbw_row_store);
            S_RSWAP:  return 32'(fbw_row_swap);
            S_DATA:   return 32'(fbw_data);
            S_CADDR:  return 32'(fbw_col_addr);
            S_WREN:   return 32'(fbw_wren);
            S_FSWAP:  return 32'(frame_swap);
            S_TMO:    return 32'(arb_timeout);
            S_NT_C0G: return 32'(nt_c0_gnt);
            S_NT_TMO: return 32'(nt_arb_timeout);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic [31:0] exp);
        sb_t e;
        e.id  = id;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Sample on the falling edge, drain all queued expectations, then move to the next cycle
    task automatic step();
        sb_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(sig_name(e.id), sig_obs(e.id), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        c0_req = 1'b0; c0_row_store = 1'b0; c0_row_swap = 1'b0; c0_wren = 1'b0; c0_frame_swap = 1'b0;
        c1_req = 1'b0; c1_row_store = 1'b0; c1_row_swap = 1'b0; c1_wren = 1'b0; c1_frame_swap = 1'b0;
        c0_row_addr = '0; c1_row_addr = '0; c0_col_addr = '0; c1_col_addr = '0;
        c0_data = '0; c1_data = '0; fbw_row_rdy = 1'b0; frame_rdy = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push_gnts(input logic g0, input logic g1);
        push(S_C0G, 32'(g0));
        push(S_C1G, 32'(g1));
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // Reset state: non-owner strobes are ignored while idle
        c0_wren = 1'b1; c0_data = 24'hABCDEF; c0_frame_swap = 1'b1; c1_wren = 1'b1;
        fbw_row_rdy = 1'b1; frame_rdy = 1'b1;
        push_gnts(1'b0, 1'b0); push(S_TMO, 32'd0); push(S_WREN, 32'd0);
        push(S_DATA, 32'd0); push(S_FSWAP, 32'd0); push(S_C0RR, 32'd0); push(S_C0FR, 32'd0);
        step();

        // Single client: grant one cycle after req, write path combinational, release on frame_swap
        clear_inputs();
        c0_req = 1'b1;
        push_gnts(1'b0, 1'b0);
        step();
        c0_wren = 1'b1; c0_col_addr = 6'd5; c0_data = 24'h123456;
        push_gnts(1'b1, 1'b0); push(S_WREN, 32'd1); push(S_CADDR, 32'd5); push(S_DATA, 32'h123456);
        step();
        c0_wren = 1'b0; c0_frame_swap = 1'b1;
        push(S_C0G, 32'd1); push(S_FSWAP, 32'd1); push(S_WREN, 32'd0);
        step();
        c0_frame_swap = 1'b0; c0_req = 1'b0;
        push_gnts(1'b0, 1'b0); push(S_FSWAP, 32'd0);
        step();
        push_gnts(1'b0, 1'b0);
        step();

        // Tie fairness over four frames, two idle cycles between grants
        do_reset();
        c0_req = 1'b1; c1_req = 1'b1;
        push_gnts(1'b0, 1'b0);
        step();
        for (int f = 0; f < 4; f++) begin
            push_gnts(f % 2 == 0, f % 2 == 1);
            step();
            c0_frame_swap = (f % 2 == 0); c1_frame_swap = (f % 2 == 1);
            push(S_FSWAP, 32'd1);
            step();
            c0_frame_swap = 1'b0; c1_frame_swap = 1'b0;
            push_gnts(1'b0, 1'b0);
            step();
            push_gnts(1'b0, 1'b0);
            step();
        end

        // Isolation: non-owner strobes never reach the frame buffer, ready goes to owner only
        do_reset();
        c0_req = 1'b1; fbw_row_rdy = 1'b1; frame_rdy = 1'b1;
        push(S_C0RR, 32'd0); push(S_C1RR, 32'd0);
        step();
        c0_row_addr = 6'd3; c1_row_addr = 6'd9; c1_wren = 1'b1; c1_row_store = 1'b1; c1_data = 24'hFFFFFF;
        push(S_C0G, 32'd1); push(S_WREN, 32'd0); push(S_RSTORE, 32'd0); push(S_RADDR, 32'd3);
        push(S_DATA, 32'd0); push(S_C0RR, 32'd1); push(S_C1RR, 32'd0); push(S_C0FR, 32'd1); push(S_C1FR, 32'd0);
        step();
        c0_wren = 1'b1; c0_data = 24'h00A5A5; c0_row_swap = 1'b1; fbw_row_rdy = 1'b0;
        push(S_WREN, 32'd1); push(S_DATA, 32'h00A5A5); push(S_RSWAP, 32'd1); push(S_C0RR, 32'd0);
        step();

        // Watchdog: TIMEOUT=8 expires after 8 idle owner cycles, TIMEOUT=0 holds the grant
        do_reset();
        c0_req = 1'b1;
        push_gnts(1'b0, 1'b0); push(S_NT_C0G, 32'd0);
        step();
        for (int i = 1; i <= 120; i++) begin
            push(S_NT_C0G, 32'd1);
            push(S_NT_TMO, 32'd0);
            if (i <= 8) begin
                push(S_C0G, 32'd1); push(S_TMO, 32'd0);
            end else if (i == 9) begin
                push(S_C0G, 32'd0); push(S_TMO, 32'd1); push(S_FSWAP, 32'd0);
            end else if (i == 10) begin
                push(S_C0G, 32'd0); push(S_TMO, 32'd0);
            end
            step();
        end

        // Abort: owner c1 drops req without frame_swap, then c0 wins the tie
        do_reset();
        c1_req = 1'b1;
        push_gnts(1'b0, 1'b0);
        step();
        push_gnts(1'b0, 1'b1);
        step();
        c1_wren = 1'b1;
        push(S_C1G, 32'd1); push(S_WREN, 32'd1);
        step();
        c1_wren = 1'b0; c1_req = 1'b0; c0_req = 1'b1;
        push(S_C1G, 32'd1); push(S_FSWAP, 32'd0);
        step();
        push_gnts(1'b0, 1'b0); push(S_FSWAP, 32'd0); push(S_TMO, 32'd0);
        step();
        c1_req = 1'b1;
        push_gnts(1'b0, 1'b0);
        step();
        push_gnts(1'b1, 1'b0);
        step();

        // Reset mid-frame while c1 owns: outputs clear, no frame_swap, c0 wins afterwards
        do_reset();
        c1_req = 1'b1;
        step();
        c1_wren = 1'b1; c1_data = 24'h55AA55;
        push(S_C1G, 32'd1); push(S_WREN, 32'd1); push(S_DATA, 32'h55AA55);
        step();
        rst = 1'b1;
        push(S_C1G, 32'd1);
        step();
        rst = 1'b0; c0_req = 1'b1; c1_frame_swap = 1'b1;
        push_gnts(1'b0, 1'b0); push(S_WREN, 32'd0); push(S_DATA, 32'd0); push(S_FSWAP, 32'd0);
        step();
        c1_frame_swap = 1'b0;
        push_gnts(1'b1, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fbw_arbiter.md
Name: fbw_arbiter

Overview:
- Shares the single frame-buffer write port between two pattern/content sources (client 0, client 1).
- Ownership is granted per frame. A client keeps the port from grant until it issues its frame_swap pulse.
- Arbitration is round-robin. The arbiter steers write traffic to the frame buffer and steers the ready signals back to the owner only.
- A programmable inactivity watchdog force-releases a stalled owner.

Parameters:
- ROW_W, 6, row address width
- COL_W, 6, column address width
- DATA_W, 24, pixel data width (RGB888)
- TIMEOUT, 4096, inactivity cycles before forced release; 0 disables the watchdog
- TO_W, 13, watchdog counter width; must hold TIMEOUT

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cN_req  in  1  client N requests frame ownership (N = 0, 1; identical set per client)
- cN_gnt  out  1  client N owns the write port
- cN_row_addr  in  ROW_W  client row address
- cN_row_store  in  1  client row store strobe
- cN_row_swap  in  1  client row swap strobe
- cN_data  in  DATA_W  client pixel data
- cN_col_addr  in  COL_W  client column address
- cN_wren  in  1  client pixel write enable
- cN_frame_swap  in  1  client end-of-frame pulse
- cN_row_rdy  out  1  fbw_row_rdy gated to the owner
- cN_frame_rdy  out  1  frame_rdy gated to the owner
- fbw_row_addr  out  ROW_W  to frame buffer
- fbw_row_store  out  1  to frame buffer
- fbw_row_rdy  in  1  from frame buffer
- fbw_row_swap  out  1  to frame buffer
- fbw_data  out  DATA_W  to frame buffer
- fbw_col_addr  out  COL_W  to frame buffer
- fbw_wren  out  1  to frame buffer
- frame_swap  out  1  to frame buffer
- frame_rdy  in  1  from frame buffer
- arb_timeout  out  1  one-cycle pulse on watchdog-forced release

Behaviour:
- Reset state:
  - FSM = ST_IDLE.
  - c0_gnt, c1_gnt, arb_timeout = 0.
  - last_owner = 1, so client 0 wins the first tie.
  - Watchdog counter = 0.
- FSM states:
  - ST_IDLE: evaluate requests.
  - ST_GRANT: a client owns the port.
  - ST_RELEASE: exactly one cycle with no grant. Every release path goes ST_GRANT -> ST_RELEASE -> ST_IDLE.
- ST_IDLE transitions:
  - Neither req set: stay in ST_IDLE.
  - Exactly one req set: grant that client.
  - Both req set: grant the client that is not last_owner.
  - Grant is registered: cN_gnt rises the cycle after req is sampled in ST_IDLE. last_owner updates at grant.
- ST_GRANT release conditions, priority order:
  1. Owner frame_swap = 1: forwarded to frame_swap in the same cycle, then release.
  2. Owner req = 0 without frame_swap: abort. frame_swap is not issued; release.
  3. Watchdog expiry: release and pulse arb_timeout for one cycle, coincident with the ST_GRANT -> ST_RELEASE transition.
  - frame_swap together with req drop counts as a normal release.
- Datapath mux (combinational on the registered grant):
  - fbw_* outputs = owner's inputs.
  - No owner (ST_IDLE, ST_RELEASE, reset): all fbw_* outputs and frame_swap = 0.
  - Strobes from a non-owner are ignored.
- Ready steering:
  - Owner: cN_row_rdy = fbw_row_rdy and cN_frame_rdy = frame_rdy.
  - Non-owner: both = 0.
  - In ST_IDLE and ST_RELEASE, all ready outputs = 0.
- Watchdog:
  - Active only in ST_GRANT, and only when TIMEOUT != 0.
  - Counter clears on entry to ST_GRANT and on any owner wren, row_store, row_swap or frame_swap.
  - Otherwise it increments each cycle.
  - Expiry is when the counter reaches TIMEOUT-1 with no activity in that cycle.
  - With TIMEOUT = 0, the counter holds at 0 and never expires.
- Latency:
  - Grant: one cycle from req.
  - Release to next possible grant: 2 cycles (ST_RELEASE, then ST_IDLE sampling).
  - Muxed write path: zero cycles, combinational.
- Reset mid-frame: grant drops the cycle after rst is sampled high; outputs go to zero; no frame_swap is emitted.

Test Plan:
- Single client: c0_req=1 at cycle 0 -> c0_gnt=1 at cycle 1. c0_wren with col 5, data 0x123456 appears on fbw_* the same cycle. c0_frame_swap -> frame_swap=1 that cycle; c0_gnt=0 next cycle.
- Tie fairness: both req held high through 4 frames -> grant order is c0, c1, c0, c1, with a 2-cycle gap between grants.
- Isolation: c1 drives wren=1 and row_store=1 while c0 owns -> fbw_wren reflects c0 only. fbw_row_rdy=1 -> c0_row_rdy=1, c1_row_rdy=0.
- Watchdog: TIMEOUT=8; c0 granted and idle -> arb_timeout pulses exactly 8 cycles after grant, c0_gnt drops, no frame_swap. With TIMEOUT=0 the grant holds 100+ idle cycles.
- Abort: c1 owner drops req mid-frame -> release, frame_swap stays 0, next tie grant goes to c0.
- Reset: rst=1 mid-frame while c1 owns -> c1_gnt=0 and all fbw_* = 0 the next cycle; after release with both requesting, c0 wins.
